// File: rtl/frame_scheduler.sv
// Per-frame sequencer for the shared VGA plotter: erase bird, erase pipes, update, draw pipes, draw bird.
// Optional drawer-phase watchdog enabled by defining FRAME_SCHEDULER_WATCHDOG_EN.
module frame_scheduler #(
  parameter int TICKS_PER_FRAME = 833334,
  parameter int CNT_W           = 20,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic bird_done,
  input  logic pipe_done,
  output logic bird_req,
  output logic pipe_req,
  output logic erase,
  output logic update,
  output logic busy,
  output logic overrun,
  output logic timeout
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, ERASE_B, ERASE_P, UPD, DRAW_P, DRAW_B
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               entry_q;
  logic               overrun_q;
  logic               tick, busy_int, drawer_wait, phase_done, wd_expire, timeout_int;

  // Gating tick with enable makes enable win over a coincident tick in WAIT_TICK.
  assign tick        = enable && (cnt_q == CNT_W'(TICKS_PER_FRAME - 1));
  assign busy_int    = !(state_q inside {IDLE, WAIT_TICK});
  assign drawer_wait = state_q inside {ERASE_B, ERASE_P, DRAW_P, DRAW_B};
  assign cnt_d       = (!enable || tick) ? '0 : cnt_q + CNT_W'(1);

  // A done pulse counts only from the drawer being waited on, and never in the req cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    phase_done = 1'b0;
    case (state_q)
      ERASE_B, DRAW_B: phase_done = bird_done && !entry_q;
      ERASE_P, DRAW_P: phase_done = pipe_done && !entry_q;
      default:         phase_done = 1'b0;
    endcase
  end

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  assign wd_expire   = drawer_wait && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_int = timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (state_d != state_q) ? '0 : wd_q + WD_W'(1);
      if (wd_expire && !phase_done) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expire          = 1'b0;
  assign timeout_int        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      entry_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      entry_q   <= (state_d != state_q);
      overrun_q <= overrun_q | (tick & busy_int);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = WAIT_TICK;
      WAIT_TICK: if (!enable) state_d = IDLE;
                 else if (tick) state_d = ERASE_B;
      ERASE_B:   if (phase_done || wd_expire) state_d = ERASE_P;
      ERASE_P:   if (phase_done || wd_expire) state_d = UPD;
      UPD:       state_d = DRAW_P;
      DRAW_P:    if (phase_done || wd_expire) state_d = DRAW_B;
      DRAW_B:    if (phase_done || wd_expire) state_d = enable ? WAIT_TICK : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bird_req = 1'b0;
    pipe_req = 1'b0;
    update   = 1'b0;
    erase    = state_q inside {ERASE_B, ERASE_P};
    busy     = busy_int;
    overrun  = overrun_q;
    timeout  = timeout_int;
    case (state_q)
      ERASE_B, DRAW_B: bird_req = entry_q;
      ERASE_P, DRAW_P: pipe_req = entry_q;
      UPD:             update   = 1'b1;
      default:         ;
    endcase
    // NOTE: reset masks the outputs combinationally so an aborted cycle issues no req or update.
    if (reset) begin
      bird_req = 1'b0;
      pipe_req = 1'b0;
      update   = 1'b0;
      erase    = 1'b0;
      busy     = 1'b0;
      overrun  = 1'b0;
      timeout  = 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: expected req/update events are queued, a monitor pops and compares.
// Build with FRAME_SCHEDULER_WATCHDOG_EN defined to also exercise the watchdog.
module tb_frame_scheduler;

  localparam int TICKS = 20;
  localparam int TOUT  = 20;

  localparam int EV_BIRD = 0, EV_PIPE = 1, EV_UPD = 2;
  localparam int C_BIRD = 0, C_PIPE = 1, C_UPD = 2, C_IDLE = 3, C_QEMPTY = 4;
  localparam int M_AUTO = 0, M_EARLY = 1, M_SILENT = 2;

  typedef struct {
    int kind;
    bit erase;
  } ev_t;

  logic clk = 1'b0;
  logic reset, enable, bird_done, pipe_done;
  logic bird_req, pipe_req, erase, update, busy, overrun, timeout;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  upd_cnt  = 0;
  int  mode     = M_AUTO;
  int  dly      = 3;
  int  n;

  frame_scheduler #(.TICKS_PER_FRAME(TICKS), .CNT_W(5), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .bird_done(bird_done), .pipe_done(pipe_done),
    .bird_req(bird_req), .pipe_req(pipe_req), .erase(erase), .update(update),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input bit er);
    ev_t e;
    e.kind  = kind;
    e.erase = er;
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    push_ev(EV_BIRD, 1'b1);
    push_ev(EV_PIPE, 1'b1);
    push_ev(EV_UPD,  1'b0);
    push_ev(EV_PIPE, 1'b0);
    push_ev(EV_BIRD, 1'b0);
  endtask

  function automatic bit cond_met(input int c);
    case (c)
      C_BIRD:   return bird_req;
      C_PIPE:   return pipe_req;
      C_UPD:    return update;
      C_IDLE:   return !busy;
      default:  return exp_q.size() == 0;
    endcase
  endfunction

  task automatic wait_for(input int c, input int limit, output int cnt);
    cnt = 0;
    while (!cond_met(c) && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    if (!cond_met(c)) check($sformatf("wait_bound_%0d", c), 0, 1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    upd_cnt = 0;
  endtask

  task automatic drive_done(input bit is_bird, input logic v);
    if (is_bird) bird_done = v;
    else         pipe_done = v;
  endtask

  // Drawer model: answers each req according to the current mode.
  initial begin
    bit is_bird;
    bird_done = 1'b0;
    pipe_done = 1'b0;
    forever begin
      if (bird_req || pipe_req) begin
        is_bird = bird_req;
        case (mode)
          M_AUTO: begin
            repeat (dly) @(negedge clk);
            drive_done(is_bird, 1'b1);
            @(negedge clk);
            drive_done(is_bird, 1'b0);
          end
          M_EARLY: begin
            drive_done(is_bird, 1'b1);
            @(negedge clk);
            drive_done(is_bird, 1'b0);
            drive_done(!is_bird, 1'b1);
            @(negedge clk);
            drive_done(!is_bird, 1'b0);
            drive_done(is_bird, 1'b1);
            @(negedge clk);
            drive_done(is_bird, 1'b0);
          end
          default: @(negedge clk);
        endcase
      end else begin
        @(negedge clk);
      end
    end
  end

  // Monitor: every req/update must match the head of the expected queue.
  initial begin
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (bird_req || pipe_req || update) begin
        check("one_hot", $countones({bird_req, pipe_req, update}), 1);
        kind = update ? EV_UPD : (pipe_req ? EV_PIPE : EV_BIRD);
        if (update) upd_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", kind, 99);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_erase", erase, e.erase);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bird_req, pipe_req, erase, update, busy, overrun, timeout}, 0);
    do_reset();

    // Normal frames, drawers answer 3 cycles after req.
    mode = M_AUTO; dly = 3;
    push_frame(); push_frame();
    reset = 1'b0; enable = 1'b1;
    wait_for(C_BIRD, 100, n);  check("first_req_latency", n, TICKS);
    wait_for(C_UPD, 100, n);   check("erase_phases_len", n, 8);
    wait_for(C_IDLE, 100, n);  check("draw_phases_len", n, 9);
    wait_for(C_BIRD, 100, n);  check("idle_gap_before_tick", n, 3);
    wait_for(C_QEMPTY, 100, n);
    wait_for(C_IDLE, 100, n);
    check("normal_overrun", overrun, 0);
    check("normal_updates", upd_cnt, 2);
    enable = 1'b0;
    do_reset();

    // Done coincident with req and done from the wrong drawer are ignored.
    mode = M_EARLY;
    push_frame();
    reset = 1'b0; enable = 1'b1;
    wait_for(C_BIRD, 100, n);
    wait_for(C_PIPE, 100, n);  check("early_done_bird_phase", n, 3);
    wait_for(C_UPD, 100, n);   check("early_done_pipe_phase", n, 3);
    wait_for(C_QEMPTY, 100, n);
    wait_for(C_IDLE, 100, n);
    enable = 1'b0;
    do_reset();

    // Slow drawers: tick during busy sets overrun and is dropped.
    mode = M_AUTO; dly = 8;
    push_frame(); push_frame();
    reset = 1'b0; enable = 1'b1;
    wait_for(C_BIRD, 100, n);
    repeat (19) @(negedge clk);
    check("overrun_before_tick", overrun, 0);
    @(negedge clk);
    check("overrun_after_tick", overrun, 1);
    wait_for(C_IDLE, 100, n);  check("slow_frame_end", n, 17);
    wait_for(C_BIRD, 100, n);  check("next_frame_on_next_tick", n, 3);
    wait_for(C_QEMPTY, 200, n);
    enable = 1'b0;
    wait_for(C_IDLE, 100, n);
    check("overrun_sticky", overrun, 1);
    check("slow_updates", upd_cnt, 2);
    do_reset();

    // enable dropped in DRAW_P: sequence completes, then IDLE.
    mode = M_AUTO; dly = 3;
    push_frame();
    reset = 1'b0; enable = 1'b1;
    wait_for(C_UPD, 100, n);
    @(negedge clk);
    enable = 1'b0;
    wait_for(C_IDLE, 100, n);  check("drop_enable_finish", n, 8);
    repeat (30) @(negedge clk);
    check("counter_held", dut.cnt_q, 0);
    check("drop_enable_no_more", exp_q.size(), 0);
    check("drop_enable_busy", busy, 0);
    do_reset();

    // Reset asserted in ERASE_P aborts the sequence.
    push_ev(EV_BIRD, 1'b1); push_ev(EV_PIPE, 1'b1);
    reset = 1'b0; enable = 1'b1;
    wait_for(C_PIPE, 100, n);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {bird_req, pipe_req, erase, update, busy, overrun, timeout}, 0);
    check("midreset_counter", dut.cnt_q, 0);
    repeat (4) @(negedge clk);
    check("midreset_queue", exp_q.size(), 0);
    push_frame();
    reset = 1'b0;
    wait_for(C_BIRD, 100, n);  check("post_reset_latency", n, TICKS);
    wait_for(C_QEMPTY, 100, n);
    enable = 1'b0;
    wait_for(C_IDLE, 100, n);
    do_reset();

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    // Bird drawer never answers: watchdog abandons the phase.
    mode = M_SILENT;
    push_ev(EV_BIRD, 1'b1); push_ev(EV_PIPE, 1'b1);
    reset = 1'b0; enable = 1'b1;
    wait_for(C_BIRD, 100, n);
    check("timeout_before", timeout, 0);
    wait_for(C_PIPE, 100, n);  check("watchdog_phase_len", n, TOUT);
    check("timeout_flag", timeout, 1);
    do_reset();
`else
    check("timeout_tied_low", timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
